// File: rtl/frame_render_sequencer_pkg.sv
// Shared types and constants for the frame render sequencer: state encoding,
// screen/grid geometry, palette and the bird row clamp.
package render_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRID,
    ST_FLOOR,
    ST_CEIL,
    ST_BIRD
  } state_t;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int CELL      = 4;
  localparam int GRID_ROWS = 30;
  localparam int GRID_COLS = 40;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] CYAN   = 3'b011;
  localparam logic [2:0] YELLOW = 3'b110;

  localparam logic [6:0] BIRD_Y_MAX = 7'd116;

  function automatic logic [6:0] clamp_bird_y(input logic [6:0] v);
    return (v > BIRD_Y_MAX) ? BIRD_Y_MAX : v;
  endfunction

endpackage

// File: rtl/frame_render_sequencer_if.sv
// Pixel port towards the VGA adapter plus the obstacle-grid bit-read port.
// The grid read is combinational: grid_bit answers grid_row/grid_col in the same cycle.
interface frame_render_sequencer_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [4:0] grid_row;
  logic [5:0] grid_col;
  logic       grid_bit;

  modport master (output x, y, colour, plot, grid_row, grid_col, input grid_bit);
  modport slave  (input x, y, colour, plot, grid_row, grid_col, output grid_bit);
endinterface

// File: rtl/frame_render_sequencer_pixel_scan_counter.sv
// Row-major px/py screen scan counter with clear, enable, wrap and end flags.
// clr wins over en; px_last/last are combinational from the current count.
module pixel_scan_counter
  import render_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] px,
  output logic [6:0] py,
  output logic       px_last,
  output logic       last
);

  assign px_last = (px == 8'(SCREEN_W - 1));
  assign last    = px_last && (py == 7'(SCREEN_H - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      px <= '0;
      py <= '0;
    end else if (en) begin
      if (px_last) begin
        px <= '0;
        py <= last ? 7'd0 : py + 7'd1;
      end else begin
        px <= px + 8'd1;
      end
    end
  end

endmodule

// File: rtl/frame_render_sequencer.sv
// One full repaint per frame_tick: obstacle grid, floor, ceiling, then the 4x4 bird.
// Pixel outputs are registered one cycle behind the scan; RENDER_COLLIDE_EN builds the bird hit test.
module frame_render_sequencer
  import render_pkg::*;
#(
  parameter int BIRD_X  = 40,
  parameter int FLOOR_Y = 110,
  parameter int CEIL_Y  = 10
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      frame_tick,
  input  logic [6:0]                bird_y,
  frame_render_sequencer_if.master  pix,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun,
  output logic                      collision
);

  state_t     state, state_n;
  logic [7:0] px;
  logic [6:0] py;
  logic       px_last, scan_last;
  logic       cnt_clr, cnt_en;
  logic [1:0] bx, by;
  logic       bird_clr, bird_en, bird_last;
  logic [6:0] bird_y_l;
  logic [7:0] addr_x, inv_x;
  logic [6:0] addr_y;
  logic       pix_v;
  logic [2:0] pix_c;
  logic       start, finish;

  pixel_scan_counter u_scan (
    .clk     (clk),
    .rst     (resetn),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .px      (px),
    .py      (py),
    .px_last (px_last),
    .last    (scan_last)
  );

  // The previous frame's last plot cycle still counts as busy for tick purposes.
  assign start     = (state == ST_IDLE) && frame_tick && !pix.plot;
  assign bird_last = (bx == 2'd3) && (by == 2'd3);

  always_comb begin
    addr_x = px;
    addr_y = py;
    case (state)
      ST_FLOOR: addr_y = 7'(FLOOR_Y);
      ST_CEIL:  addr_y = 7'(CEIL_Y);
      ST_BIRD: begin
        addr_x = 8'(BIRD_X) + {6'd0, bx};
        addr_y = bird_y_l + {5'd0, by};
      end
      default: ;
    endcase
  end

  // Grid column 0 sits at the right edge of the screen.
  assign inv_x        = 8'(SCREEN_W - 1) - addr_x;
  assign pix.grid_row = 5'(addr_y / 7'(CELL));
  assign pix.grid_col = 6'(inv_x / 8'(CELL));

  always_ff @(posedge clk) begin
    if (resetn) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    bird_clr = 1'b0;
    bird_en  = 1'b0;
    pix_v    = 1'b0;
    pix_c    = BLACK;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_GRID;
          cnt_clr  = 1'b1;
          bird_clr = 1'b1;
        end
      end
      ST_GRID: begin
        pix_v  = 1'b1;
        pix_c  = pix.grid_bit ? CYAN : BLACK;
        cnt_en = 1'b1;
        if (scan_last) begin
          state_n = ST_FLOOR;
          cnt_clr = 1'b1;
        end
      end
      ST_FLOOR, ST_CEIL: begin
        pix_v  = 1'b1;
        pix_c  = GREEN;
        cnt_en = 1'b1;
        if (px_last) begin
          state_n = (state == ST_FLOOR) ? ST_CEIL : ST_BIRD;
          cnt_clr = 1'b1;
        end
      end
      ST_BIRD: begin
        pix_v   = 1'b1;
        pix_c   = YELLOW;
        bird_en = 1'b1;
        if (bird_last) begin
          state_n = ST_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      pix.x      <= '0;
      pix.y      <= '0;
      pix.colour <= '0;
      pix.plot   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      bird_y_l   <= '0;
      bx         <= '0;
      by         <= '0;
    end else begin
      pix.plot   <= pix_v;
      frame_done <= finish;
      if (pix_v) begin
        pix.x      <= addr_x;
        pix.y      <= addr_y;
        pix.colour <= pix_c;
      end
      if (start)       busy <= 1'b1;
      else if (finish) busy <= 1'b0;
      if (frame_tick && !start) overrun <= 1'b1;
      if (start) bird_y_l <= clamp_bird_y(bird_y);
      if (bird_clr) begin
        bx <= '0;
        by <= '0;
      end else if (bird_en) begin
        bx <= bx + 2'd1;
        if (bx == 2'd3) by <= by + 2'd1;
      end
    end
  end

`ifdef RENDER_COLLIDE_EN
  logic hit_acc, hit_now;

  assign hit_now = (state == ST_BIRD) &&
                   (pix.grid_bit || addr_y == 7'(FLOOR_Y) || addr_y == 7'(CEIL_Y));

  always_ff @(posedge clk) begin
    if (resetn) begin
      hit_acc   <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (start)        hit_acc <= 1'b0;
      else if (hit_now) hit_acc <= 1'b1;
      if (finish) collision <= hit_acc || hit_now;
    end
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_frame_render_sequencer.sv
// Directed bench for frame_render_sequencer: full frames against a behavioural
// obstacle grid, overrun, bird clamp, collision (when built in) and mid-frame reset.
module tb_frame_render_sequencer;
  import render_pkg::*;

  localparam int TOTAL = 19536;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [6:0] bird_y = '0;
  logic       busy, frame_done, overrun, collision;

  logic [GRID_COLS-1:0] grid_mem [GRID_ROWS];
  logic cell2_set = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  frame_render_sequencer_if pif ();

  assign pif.grid_bit = (pif.grid_row < 5'(GRID_ROWS) && pif.grid_col < 6'(GRID_COLS)) ?
                        grid_mem[pif.grid_row][pif.grid_col] : 1'b0;

  frame_render_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .bird_y     (bird_y),
    .pix        (pif),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected grid colour from the hand-placed cells: row0/col0 and optionally row12/col29.
  function automatic logic [2:0] exp_grid(input int x, input int y);
    if (x >= 156 && y < 4) return 3'b011;
    if (cell2_set && x >= 40 && x <= 43 && y >= 48 && y <= 51) return 3'b011;
    return 3'b000;
  endfunction

  task automatic run_frame(input logic [6:0] by_in, input logic [6:0] by_exp,
                           input int tick_at, input logic exp_coll, input int exp_cyan);
    int k = 0, cyc = 0, gaps = 0, cyan = 0;
    int grid_err = 0, line_err = 0, bird_err = 0, first_cyc = -1;
    logic seen_done = 1'b0;
    bird_y = by_in;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("busy_start", busy, 1);
    while (!seen_done && cyc < 20000) begin
      if (cyc == tick_at) frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      cyc++;
      if (pif.plot) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (k < 19200) begin
          if (pif.x != 8'(k % 160) || pif.y != 7'(k / 160) ||
              pif.colour != exp_grid(k % 160, k / 160)) grid_err++;
          if (pif.colour == 3'b011) cyan++;
        end else if (k < 19520) begin
          if (pif.x != 8'((k - 19200) % 160) || pif.colour != 3'b010 ||
              pif.y != ((k < 19360) ? 7'd110 : 7'd10)) line_err++;
        end else begin
          if (pif.x != 8'(40 + (k - 19520) % 4) || pif.colour != 3'b110 ||
              pif.y != by_exp + 7'((k - 19520) / 4)) bird_err++;
        end
        k++;
      end else if (k > 0) begin
        gaps++;
      end
      if (frame_done) begin
        seen_done = 1'b1;
        chk("done_plot", pif.plot, 1);
        chk("done_busy", busy, 0);
        chk("done_x", pif.x, 43);
        chk("done_y", pif.y, by_exp + 7'd3);
        chk("done_colour", pif.colour, 3'b110);
        chk("collision", collision, exp_coll);
      end
    end
    chk("frame_done_seen", seen_done, 1);
    chk("plot_count", k, TOTAL);
    chk("plot_start", first_cyc, 1);
    chk("plot_gaps", gaps, 0);
    chk("grid_px_err", grid_err, 0);
    chk("line_px_err", line_err, 0);
    chk("bird_px_err", bird_err, 0);
    chk("cyan_count", cyan, exp_cyan);
    @(negedge clk);
    chk("after_plot", pif.plot, 0);
    chk("after_done", frame_done, 0);
    chk("after_x_hold", pif.x, 43);
  endtask

  initial begin
    int k, cyc, dn, pl;
    logic coll_on;
`ifdef RENDER_COLLIDE_EN
    coll_on = 1'b1;
`else
    coll_on = 1'b0;
`endif
    for (int r = 0; r < GRID_ROWS; r++) grid_mem[r] = '0;

    resetn = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_x", pif.x, 0);
    chk("rst_y", pif.y, 0);
    chk("rst_colour", pif.colour, 0);
    chk("rst_plot", pif.plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_collision", collision, 0);

    // Frame 1: cells (0,0) and (12,29); bird over (12,29) at rows 48..51.
    grid_mem[0][0]   = 1'b1;
    grid_mem[12][29] = 1'b1;
    cell2_set        = 1'b1;
    run_frame(7'd48, 7'd48, -1, coll_on, 32);
    chk("no_overrun", overrun, 0);

    // Frame 2: cell under the bird cleared, bird_y clamped, a tick 5000 cycles in.
    grid_mem[12][29] = 1'b0;
    cell2_set        = 1'b0;
    run_frame(7'd120, 7'd116, 5000, 1'b0, 16);
    chk("overrun_set", overrun, 1);

    // Frame 3: reset while drawing the bird.
    bird_y = 7'd50;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 19525 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (pif.plot) k++;
    end
    chk("rst_reach_bird", k, 19525);
    chk("overrun_sticky", overrun, 1);
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    chk("midrst_plot", pif.plot, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", frame_done, 0);
    chk("midrst_overrun", overrun, 0);
    dn = 0;
    pl = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_done) dn++;
      if (pif.plot) pl++;
    end
    chk("midrst_no_done", dn, 0);
    chk("midrst_no_plot", pl, 0);

    // Frame 4: clean frame after reset; bird rows 108..111 cross the floor line.
    run_frame(7'd108, 7'd108, -1, coll_on, 16);
    chk("final_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_render_sequencer.md
Name: frame_render_sequencer

Overview:
Sequences one full screen repaint per frame tick onto the single VGA adapter pixel port (160x120, 3-bit colour, plot).
- Draw order is fixed: obstacle grid (covers the whole screen), then floor line, then ceiling line, then the 4x4 bird sprite.
- Reads the 30x40 obstacle shift-register array through a row/column bit-read port.
- Sits between the obstacle datapath and vga_adapter, replacing the ad-hoc draw states in the top level.

Parameters:
- BIRD_X, 40, left pixel column of the bird sprite.
- FLOOR_Y, 110, pixel row of the floor line.
- CEIL_Y, 10, pixel row of the ceiling line.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  synchronous reset, active-high. The name is kept per codebase convention; the polarity is fixed as active-high.
- frame_tick  in  1  one-cycle pulse that requests a repaint.
- bird_y  in  7  bird top pixel row, latched at frame start.
- grid_row  out  5  obstacle row being read (0..29), combinational from the scan counters.
- grid_col  out  6  obstacle column being read (0..39), combinational.
- grid_bit  in  1  obstacle bit at grid_row/grid_col, valid in the same cycle.
- x  out  8  pixel x to vga_adapter, registered.
- y  out  7  pixel y, registered.
- colour  out  3  pixel colour, registered.
- plot  out  1  write strobe, registered.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse, coincident with the last plot.
- overrun  out  1  sticky; set when frame_tick arrives while busy.
- collision  out  1  bird hit result for the last completed frame.

Behaviour:
- Reset (resetn=1 at a clk edge): state=IDLE; x=0, y=0, colour=0, plot=0, busy=0, frame_done=0, overrun=0, collision=0. Reset mid-frame aborts the frame immediately; the next cycle is IDLE with plot=0.
- States: IDLE -> GRID -> FLOOR -> CEIL -> BIRD -> IDLE.
- IDLE: frame_tick=1 latches bird_y (values above 116 clamp to 116), clears the scan counters, enters GRID, and sets busy=1.
- Scan counters: px 0..159 (8b) and py 0..119 (7b), row-major. px wraps 159->0 and increments py.
- GRID: grid_row = py>>2; grid_col = (159-px)>>2, so column 0 occupies x 156..159. Colour is 3'b011 if grid_bit else 3'b000. Leaves after px=159, py=119 (19200 cycles).
- FLOOR: px 0..159 at y=FLOOR_Y, colour 3'b010 (160 cycles).
- CEIL: same as FLOOR at y=CEIL_Y (160 cycles).
- BIRD: 2-bit counters bx, by over x=BIRD_X+bx, y=bird_y_latched+by, colour 3'b110 (16 cycles). grid_row/grid_col address the cell under the current bird pixel.
- Output registers capture each scan cycle's pixel at the next edge. plot is therefore high for exactly 19536 consecutive cycles, starting 2 cycles after the frame_tick edge.
- frame_done and busy=0 take effect in the same cycle as the last plot. The outputs that cycle are x=BIRD_X+3, y=bird_y+3.
- frame_tick while busy (including the last-plot cycle) is ignored and sets overrun=1. overrun stays set until reset.
- Outside a frame: plot=0; x, y, colour hold their last values.

Optional Feature:
- Macro: RENDER_COLLIDE_EN.
- With the macro: during BIRD, a hit accumulator ORs grid_bit together with (bird pixel y == FLOOR_Y or CEIL_Y). collision takes the accumulator value at the frame_done cycle and holds it until the next frame_done. The accumulator clears at frame start.
- Without the macro: the collision port exists and is tied 0; no accumulator logic is built.

Decomposition:
- Package render_pkg:
  - state encoding (IDLE/GRID/FLOOR/CEIL/BIRD);
  - SCREEN_W=160, SCREEN_H=120, CELL=4, GRID_ROWS=30, GRID_COLS=40;
  - colour constants BLACK=000, GREEN=010, CYAN=011, YELLOW=110;
  - BIRD_Y_MAX=116.
- One sub-module, pixel_scan_counter: px/py counter with clear, enable, wrap and last flag. Shared by GRID and FLOOR/CEIL (FLOOR/CEIL use only px).

Test Plan:
- Reset, then a frame_tick with all grid bits 0 and bird_y=50 -> plot high for 19536 cycles; frame_done pulses once on the final plot with x=43, y=53, colour=110; busy falls in the same cycle.
- grid_bit=1 only for row 0, col 0 -> GRID pixels x156..159, y0..3 have colour 011; every other GRID pixel is 000; grid_col=0 while px is 156..159.
- Check the line phases -> 160 plots at y=110 with colour 010, followed by 160 plots at y=10 with colour 010; x runs 0..159 in order.
- frame_tick pulsed 5000 cycles into a frame -> the frame is not restarted, plot count stays 19536, overrun=1 and stays high across later frames until reset.
- RENDER_COLLIDE_EN, bird_y=48, grid cell row 12, col 29 set (x 40..43) -> collision=1 at frame_done. A next frame with the cell cleared -> collision=0. bird_y=108 -> collision=1 from the floor row.
- resetn asserted during BIRD -> next cycle plot=0, busy=0, no frame_done. A frame_tick afterwards starts a clean frame.
